addition_control_unit: RTL and testbench

ADDITION_CONTROL_UNIT -- requirements
Module: addition_control_unit

---
 rtl/fp_add_pkg.sv | 21 ++
 rtl/shift_amount_calc.sv | 24 ++
 rtl/addition_control_unit.sv | 120 ++++++++++++
 tb/tb_addition_control_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared definitions for the floating-point adder control path.
package fp_add_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  localparam int unsigned MENT_WIDTH_DEFAULT = 23;
  localparam int unsigned MAX_SHIFT          = MENT_WIDTH_DEFAULT + 1;

  // Largest useful alignment/normalisation distance: mantissa plus hidden bit.
  function automatic int unsigned max_shift_for(input int unsigned ment_width);
    return ment_width + 1;
  endfunction

endpackage

// File: rtl/shift_amount_calc.sv
// Alignment shift distance: magnitude of the exponent difference, saturated.
module shift_amount_calc
  import fp_add_pkg::*;
#(
  parameter int unsigned EXPO_WIDTH  = 8,
  parameter int unsigned SHIFT_LIMIT = MAX_SHIFT
) (
  input  logic [EXPO_WIDTH:0] diff,
  output logic [4:0]          shift_amt
);

  logic [EXPO_WIDTH-1:0] mag;

  // Sign bit set means exponent1 >= exponent2, so the low bits are already the magnitude.
  always_comb begin
    mag = diff[EXPO_WIDTH] ? diff[EXPO_WIDTH-1:0] : -diff[EXPO_WIDTH-1:0];
    if (mag > EXPO_WIDTH'(SHIFT_LIMIT)) begin
      shift_amt = 5'(SHIFT_LIMIT);
    end else begin
      shift_amt = mag[4:0];
    end
  end

endmodule

// File: rtl/addition_control_unit.sv
// Sequencer for a multi-cycle floating-point adder: compare, align, add, normalise.
module addition_control_unit
  import fp_add_pkg::*;
#(
  parameter int unsigned EXPO_WIDTH = 8,
  parameter int unsigned MENT_WIDTH = MENT_WIDTH_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                start_in,
  input  logic [EXPO_WIDTH:0] exp_diff_in,
  input  logic                carry_in,
  input  logic                msb_in,
  input  logic                zero_in,
  output logic                mux1_sel_out,
  output logic                mux2_sel_out,
  output logic                mux3_sel_out,
  output logic [4:0]          shift_amt_out,
  output logic                align_en_out,
  output logic                add_en_out,
  output logic                norm_right_out,
  output logic                norm_left_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam logic [4:0] SHIFT_LIMIT = 5'(max_shift_for(MENT_WIDTH));

  state_t              state;
  logic [EXPO_WIDTH:0] diff_q;
  logic [4:0]          norm_cnt;
  logic [4:0]          shift_calc;

  shift_amount_calc #(
    .EXPO_WIDTH (EXPO_WIDTH),
    .SHIFT_LIMIT(int'(SHIFT_LIMIT))
  ) u_shift_amount_calc (
    .diff     (diff_q),
    .shift_amt(shift_calc)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      diff_q         <= '0;
      norm_cnt       <= '0;
      mux1_sel_out   <= 1'b0;
      mux2_sel_out   <= 1'b0;
      mux3_sel_out   <= 1'b0;
      shift_amt_out  <= '0;
      align_en_out   <= 1'b0;
      add_en_out     <= 1'b0;
      norm_right_out <= 1'b0;
      norm_left_out  <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
    end else begin
      align_en_out   <= 1'b0;
      add_en_out     <= 1'b0;
      norm_right_out <= 1'b0;
      norm_left_out  <= 1'b0;
      done_out       <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state        <= COMPARE;
            busy_out     <= 1'b1;
            diff_q       <= exp_diff_in;
            mux1_sel_out <= exp_diff_in[EXPO_WIDTH];
            mux2_sel_out <= exp_diff_in[EXPO_WIDTH];
            mux3_sel_out <= exp_diff_in[EXPO_WIDTH];
          end
        end
        COMPARE: begin
          state         <= ALIGN;
          shift_amt_out <= shift_calc;
          align_en_out  <= 1'b1;
        end
        ALIGN: begin
          state      <= ADD;
          add_en_out <= 1'b1;
        end
        ADD: begin
          state    <= NORM;
          norm_cnt <= '0;
        end
        NORM: begin
          // A right shift parks the counter at its limit so the next cycle exits.
          if (zero_in || norm_cnt == SHIFT_LIMIT) begin
            state    <= DONE;
            done_out <= 1'b1;
          end else if (carry_in) begin
            norm_right_out <= 1'b1;
            norm_cnt       <= SHIFT_LIMIT;
          end else if (!msb_in) begin
            norm_left_out <= 1'b1;
            norm_cnt      <= norm_cnt + 5'd1;
          end else begin
            state    <= DONE;
            done_out <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          busy_out      <= 1'b0;
          diff_q        <= '0;
          norm_cnt      <= '0;
          mux1_sel_out  <= 1'b0;
          mux2_sel_out  <= 1'b0;
          mux3_sel_out  <= 1'b0;
          shift_amt_out <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addition_control_unit.sv
// Randomised and directed checks of addition_control_unit against a cycle trace model.
module tb_addition_control_unit;

  typedef logic [13:0] vec_t;  // {sel1,sel2,sel3,shift[4:0],align,add,right,left,busy,done}

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] exp_diff;
  logic       carry, msb, zero;
  logic       mux1_sel, mux2_sel, mux3_sel;
  logic [4:0] shift_amt;
  logic       align_en, add_en, norm_right, norm_left, busy, done;
  vec_t       obs_vec;

  int n_cmp = 0;
  int n_bad = 0;

  logic zero_seq [32];
  logic carry_seq[32];
  logic msb_seq  [32];
  vec_t exp_tr   [64];
  int   exp_d;
  int   exp_left_n;

  always #5 clk = ~clk;

  addition_control_unit #(.EXPO_WIDTH(8), .MENT_WIDTH(23)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .exp_diff_in   (exp_diff),
    .carry_in      (carry),
    .msb_in        (msb),
    .zero_in       (zero),
    .mux1_sel_out  (mux1_sel),
    .mux2_sel_out  (mux2_sel),
    .mux3_sel_out  (mux3_sel),
    .shift_amt_out (shift_amt),
    .align_en_out  (align_en),
    .add_en_out    (add_en),
    .norm_right_out(norm_right),
    .norm_left_out (norm_left),
    .busy_out      (busy),
    .done_out      (done)
  );

  assign obs_vec = {mux1_sel, mux2_sel, mux3_sel, shift_amt,
                    align_en, add_en, norm_right, norm_left, busy, done};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [4:0] sh, input logic [5:0] lo);
    return {s, s, s, sh, lo};
  endfunction

  // kind: 0 msb high, 1 carry, 2 msb low 3 cycles, 3 zero, 4 msb always low, 5 random
  task automatic set_seq(input int kind);
    for (int j = 0; j < 32; j++) begin
      zero_seq[j]  = 1'b0;
      carry_seq[j] = 1'b0;
      msb_seq[j]   = 1'b1;
      case (kind)
        1: begin carry_seq[j] = (j == 0); msb_seq[j] = 1'b0; end
        2: msb_seq[j] = (j >= 3);
        3: begin zero_seq[j] = 1'b1; msb_seq[j] = 1'b0; carry_seq[j] = 1'b1; end
        4: msb_seq[j] = 1'b0;
        5: begin
          zero_seq[j]  = ($urandom_range(15) == 0);
          carry_seq[j] = ($urandom_range(7) == 0);
          msb_seq[j]   = ($urandom_range(3) == 0);
        end
        default: ;
      endcase
    end
  endtask

  // Expected per-cycle outputs after a start, cycle 1 = COMPARE.
  task automatic build_model(input logic [8:0] d);
    int       low, mag, sh, pulses, c, j;
    logic     s;
    logic [4:0] sh5;
    bit       after_right, ending;
    s    = d[8];
    low  = int'(d[7:0]);
    mag  = s ? low : (256 - low) % 256;
    sh   = (mag > 24) ? 24 : mag;
    sh5  = 5'(sh);
    for (int k = 0; k < 64; k++) exp_tr[k] = '0;
    exp_tr[1] = mk(s, 5'd0, 6'b000010);
    exp_tr[2] = mk(s, sh5,  6'b100010);
    exp_tr[3] = mk(s, sh5,  6'b010010);
    exp_tr[4] = mk(s, sh5,  6'b000010);
    pulses = 0; after_right = 1'b0; c = 4; j = 0; exp_d = 0;
    while (exp_d == 0 && j < 32) begin
      ending = zero_seq[j] || after_right || pulses == 24 || (!carry_seq[j] && msb_seq[j]);
      if (ending) begin
        exp_tr[c+1] = mk(s, sh5, 6'b000011);
        exp_d = c + 1;
      end else if (carry_seq[j]) begin
        exp_tr[c+1] = mk(s, sh5, 6'b001010);
        after_right = 1'b1;
      end else begin
        exp_tr[c+1] = mk(s, sh5, 6'b000110);
        pulses++;
      end
      c++;
      j++;
    end
    exp_left_n = pulses;
  endtask

  // Called #1 after a clock edge with the DUT idle.
  task automatic run_op(input string name, input logic [8:0] d, input bit poke);
    int obs_d, left_obs;
    build_model(d);
    exp_diff = d; start = 1'b1; zero = 1'b0; carry = 1'b0; msb = 1'b1;
    obs_d = -1; left_obs = 0;
    for (int c = 1; c <= exp_d + 2; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("%s cyc%0d", name, c), 32'(obs_vec), 32'(exp_tr[c]));
      if (done && obs_d < 0) obs_d = c;
      if (norm_left) left_obs++;
      if (c >= 4 && c - 4 < 32) begin
        zero = zero_seq[c-4]; carry = carry_seq[c-4]; msb = msb_seq[c-4];
      end
      if (poke && c <= exp_d) begin
        start    = 1'($urandom_range(1));
        exp_diff = 9'($urandom);
      end
    end
    check({name, " latency"}, 32'(obs_d), 32'(exp_d));
    check({name, " left_pulses"}, 32'(left_obs), 32'(exp_left_n));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; exp_diff = '0; carry = 1'b0; msb = 1'b0; zero = 1'b0;
    #1;
    check("reset_state", 32'(obs_vec), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    set_seq(0); run_op("d102", 9'h102, 1'b0);
    check("d102 min_latency", 32'(exp_d), 32'd5);
    set_seq(0); run_op("d0FE", 9'h0FE, 1'b0);
    set_seq(0); run_op("d100", 9'h100, 1'b0);
    set_seq(0); run_op("d1C8_sat", 9'h1C8, 1'b0);
    set_seq(1); run_op("carry", 9'h105, 1'b0);
    set_seq(2); run_op("left3", 9'h0F0, 1'b0);
    set_seq(3); run_op("zero", 9'h101, 1'b0);
    set_seq(4); run_op("left_max", 9'h103, 1'b0);
    check("left_max count", 32'(exp_left_n), 32'd24);
    set_seq(0); run_op("busy_start", 9'h110, 1'b1);

    // Asynchronous reset while normalising.
    set_seq(4);
    exp_diff = 9'h104; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    zero = 1'b0; carry = 1'b0; msb = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("rst_async", 32'(obs_vec), 32'd0);
    @(posedge clk); #1;
    check("rst_held", 32'(obs_vec), 32'd0);
    rst = 1'b0;
    set_seq(0); run_op("after_rst", 9'h0FD, 1'b0);

    for (int i = 0; i < 20; i++) begin
      set_seq(5);
      run_op($sformatf("rnd%0d", i), 9'($urandom), 1'(i % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
